// File: rtl/offset_out_pipe.sv
// Signed-to-offset-binary DAC output pipeline: round/clip stage (S1), offset/output stage (S2),
// valid/ready handshake on both sides and sticky clip statistics.
module offset_out_pipe #(
    parameter int W_IN  = 19,
    parameter int W_OUT = 8,
    parameter int W_CNT = 16
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic signed [W_IN-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   rnd_en,
    input  logic                   sat_en,
    output logic [W_OUT-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clr_clip,
    output logic                   clip_flag,
    output logic [W_CNT-1:0]       clip_cnt
);

    localparam int D = W_IN - W_OUT;
    localparam logic signed [W_IN:0] RND_C  = {{(W_IN-D+1){1'b0}}, 1'b1, {(D-1){1'b0}}};
    localparam logic [W_OUT-1:0]     MID_C  = {1'b1, {(W_OUT-1){1'b0}}};
    localparam logic [W_OUT-1:0]     SAT_HI = {1'b0, {(W_OUT-1){1'b1}}};
    localparam logic [W_OUT-1:0]     SAT_LO = {1'b1, {(W_OUT-1){1'b0}}};
    localparam logic [W_CNT-1:0]     CNT_ONE = {{(W_CNT-1){1'b0}}, 1'b1};

    // One guard bit above W_IN keeps the half-LSB rounding add from overflowing.
    function automatic logic signed [W_OUT:0] round_shift(input logic signed [W_IN-1:0] x,
                                                          input logic rnd);
        logic signed [W_IN:0] ext;
        logic signed [W_IN:0] sh;
        ext = {x[W_IN-1], x};
        if (rnd) ext = ext + RND_C;
        sh = ext >>> D;
        return sh[W_OUT:0];
    endfunction

    function automatic logic is_clip(input logic signed [W_OUT:0] r);
        return r[W_OUT] ^ r[W_OUT-1];
    endfunction

    function automatic logic [W_OUT-1:0] sat_wrap(input logic signed [W_OUT:0] r,
                                                  input logic sat);
        if (sat && is_clip(r)) return r[W_OUT] ? SAT_LO : SAT_HI;
        return r[W_OUT-1:0];
    endfunction

    logic signed [W_OUT:0] r_p0;
    logic                  s2_load, accept, clip_ev;
    logic                  vld_p1_q, vld_p1_d, clip_p1_q, clip_p1_d;
    logic [W_OUT-1:0]      data_p1_q, data_p1_d;
    logic                  vld_p2_q, vld_p2_d;
    logic [W_OUT-1:0]      data_p2_q, data_p2_d;
    logic                  clip_flag_q, clip_flag_d;
    logic [W_CNT-1:0]      clip_cnt_q, clip_cnt_d;

    assign s2_load  = !vld_p2_q || out_ready;
    assign in_ready = !vld_p1_q || s2_load;
    assign accept   = in_valid && in_ready;
    assign clip_ev  = s2_load && vld_p1_q && clip_p1_q;

    always_comb begin
        r_p0      = round_shift(in_data, rnd_en);
        vld_p1_d  = in_ready ? in_valid : vld_p1_q;
        data_p1_d = accept ? sat_wrap(r_p0, sat_en) : data_p1_q;
        clip_p1_d = accept ? is_clip(r_p0) : clip_p1_q;
        vld_p2_d  = s2_load ? vld_p1_q : vld_p2_q;
        // S2 only reloads on a real sample so the DAC holds its last code while idle.
        data_p2_d = (s2_load && vld_p1_q) ? {~data_p1_q[W_OUT-1], data_p1_q[W_OUT-2:0]}
                                          : data_p2_q;
        clip_flag_d = clip_flag_q;
        clip_cnt_d  = clip_cnt_q;
        if (clr_clip) begin
            clip_flag_d = clip_ev;
            clip_cnt_d  = clip_ev ? CNT_ONE : '0;
        end else if (clip_ev) begin
            clip_flag_d = 1'b1;
            if (clip_cnt_q != '1) clip_cnt_d = clip_cnt_q + CNT_ONE;
        end
    end

    // S1 / S2 boundary: control state
    always_ff @(posedge CLK) begin
        if (Reset) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            data_p2_q   <= MID_C;
            clip_flag_q <= 1'b0;
            clip_cnt_q  <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            data_p2_q   <= data_p2_d;
            clip_flag_q <= clip_flag_d;
            clip_cnt_q  <= clip_cnt_d;
        end
    end

    // S1 datapath (qualified by vld_p1_q)
    always_ff @(posedge CLK) begin
        data_p1_q <= data_p1_d;
        clip_p1_q <= clip_p1_d;
    end

    assign out_data  = data_p2_q;
    assign out_valid = vld_p2_q;
    assign clip_flag = clip_flag_q;
    assign clip_cnt  = clip_cnt_q;

endmodule

// File: doc/offset_out_pipe.md
OFFSET_OUT_PIPE -- requirements
Module: offset_out_pipe

Interface
REQ-001 Parameter W_IN, default 19, signed input sample width; SHALL satisfy W_IN > W_OUT + 1.
REQ-002 Parameter W_OUT, default 8, offset-binary output width (DAC word).
REQ-003 Parameter W_CNT, default 16, clip counter width.
REQ-004 CLK  input  1  clock; all state SHALL change only on its rising edge.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  W_IN  two's-complement sample.
REQ-007 in_valid  input  1  in_data qualifier.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 rnd_en  input  1  1 = round half-up, 0 = truncate; sampled with the accepted sample.
REQ-010 sat_en  input  1  1 = saturate, 0 = wrap; sampled with the accepted sample.
REQ-011 out_data  output  W_OUT  offset-binary result (MSB-inverted two's complement).
REQ-012 out_valid  output  1  out_data qualifier.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 clr_clip  input  1  clears clip statistics.
REQ-015 clip_flag  output  1  sticky: a clip event occurred since the last clear or reset.
REQ-016 clip_cnt  output  W_CNT  saturating count of clip events.

Function
REQ-017 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-018 Two register stages, S1 (round/clip) and S2 (offset/output), each with its own valid bit; out_valid SHALL equal the S2 valid bit.
REQ-019 S2 SHALL load when !S2_valid || out_ready. S1 SHALL advance when S2 loads. in_ready SHALL equal !S1_valid || S2 loads (combinational from out_ready).
REQ-020 Latency SHALL be exactly 2 cycles from input transfer to out_valid when not stalled. Throughput SHALL be 1 sample/cycle with out_ready held high.
REQ-021 Arithmetic: D = W_IN - W_OUT. Compute x sign-extended to W_IN+1 bits, plus 2^(D-1) if rnd_en. Then arithmetic right shift by D gives r, W_OUT+1 bits signed.
REQ-022 Clip event: r < -2^(W_OUT-1) or r > 2^(W_OUT-1)-1. The event SHALL be flagged independent of sat_en.
REQ-023 sat_en=1: clipped r SHALL become the nearest bound. sat_en=0: the low W_OUT bits of r SHALL be used (wrap).
REQ-024 out_data SHALL be the W_OUT-bit result with its MSB inverted (signed 0 -> 2^(W_OUT-1)).
REQ-025 While out_valid && !out_ready, out_data and out_valid SHALL stay stable and no sample SHALL be dropped or duplicated.
REQ-026 While out_valid is low, out_data SHALL hold the last value loaded into S2 (DAC hold).
REQ-027 Clip statistics SHALL update once per clip event, at the cycle the sample leaves S1 into S2. Stalled samples SHALL NOT be recounted.
REQ-028 clip_cnt SHALL saturate at 2^W_CNT-1 and not wrap.
REQ-029 If clr_clip is asserted in the same cycle as a clip event, the result SHALL be clip_cnt=1 and clip_flag=1. clr_clip alone SHALL give 0 and 0.
REQ-030 rnd_en/sat_en changes SHALL affect only samples accepted after the change.

Reset
REQ-031 With Reset high at a clock edge, S1/S2 valid, out_valid and clip_flag SHALL be 0, and clip_cnt SHALL be 0.
REQ-032 Reset SHALL set out_data to midscale 2^(W_OUT-1) (0x80 at default).
REQ-033 in_ready SHALL be 1 in the first cycle after Reset deasserts.
REQ-034 Reset SHALL override all other inputs, including mid-stall. In-flight samples SHALL be discarded without counting clips.

Verification (defaults W_IN=19, W_OUT=8)
REQ-035 in_data=0x00000, out_ready=1 -> out_data=0x80, out_valid exactly 2 cycles after accept, clip_flag=0.
REQ-036 in_data=0x00400, rnd_en=0 -> 0x80; rnd_en=1 -> 0x81. in_data=0x40000 (-2^18) -> 0x00.
REQ-037 in_data=0x3FFFF, rnd_en=1, sat_en=1 -> 0xFF, clip_cnt=1, clip_flag=1. Same sample with sat_en=0 -> 0x00 (wrap), clip_cnt=2.
REQ-038 Stream 5 samples with out_ready low for 3 cycles mid-stream -> in_ready drops after both stages fill, output data held, all 5 samples delivered in order, no duplicates.
REQ-039 clr_clip in the same cycle as a clip event -> clip_cnt=1. Force 2^16+3 clip events -> clip_cnt=0xFFFF.
REQ-040 Reset asserted with both stages valid and out_ready=0 -> next cycle out_valid=0, out_data=0x80, clip_cnt=0, in_ready=1.
